arm_lsu: RTL and testbench
==========================

Name: arm_lsu

Overview:
Load/store unit; the initiator side of one port of the two-port word memory (port 1 = data port). It accepts byte/halfword/word load and store requests from the core pipeline and issues word-aligned big-endian accesses to memory. Sub-word stores are done as read-modify-write, because the memory writes whole words only. It reports data and faults back to the core with a single-cycle response pulse.

Parameters:
ALIGN_CHECK, 1, 1 = misaligned halfword/word raises a fault; 0 = low address bits are forced to the natural alignment.
RESET_RDATA, 32'h0, reset/idle value of resp_rdata.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
req_valid  in  1  core request valid.
req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
req_write  in  1  1 = store, 0 = load.
req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as misaligned.
req_signed  in  1  sign-extend load data.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-justified.
resp_valid  out  1  one-cycle completion pulse; no backpressure.
resp_rdata  out  32  load result, extended; 0 for stores.
resp_fault  out  2  0 = ok, 1 = misaligned, 2 = memory exception.
mem_addr  out  32  word-aligned address to memory.
mem_wdata  out  32  write data to memory.
mem_we  out  1  memory write enable.
mem_excpt  in  1  memory decode exception (combinational from mem_addr).
mem_rdata  in  32  memory combinational read data, big-endian.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - resp_valid = 0, resp_fault = 0, resp_rdata = RESET_RDATA.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - req_ready = 1 once rst_n is released.
- States: IDLE, RD, WR, RESP.
  - mem_we = 1 only in WR.
  - mem_addr = {addr_q[31:2], 2'b00} in RD/WR, else 0.
  - mem_wdata = merged word in WR, else 0.
- On accept, register addr, size, signed, write, wdata. Misalignment check: half with addr[0] = 1, word with addr[1:0] != 0, or size = 3.
  - Misaligned and ALIGN_CHECK = 1: go to RESP with fault = 1. No memory access.
  - Load: go to RD.
  - Word store: go to WR.
  - Byte/half store: go to RD.
- RD:
  - mem_excpt = 1: go to RESP, fault = 2. No write occurs.
  - Load: extract the lane, register it into resp_rdata, go to RESP.
  - Sub-word store: register mem_rdata with the new lane merged in, go to WR.
- Lane mapping (big-endian):
  - Byte: offset 0 = bits [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0].
  - Half: addr[1] = 0 → [31:16], 1 → [15:0].
  - Zero- or sign-extend per req_signed.
- WR: one cycle with mem_we = 1. The memory commits at the end-of-cycle edge. mem_excpt = 1 gives fault = 2 (the memory suppresses the write). Next state is RESP.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. resp_rdata and resp_fault hold until the next RESP.
- Latency from accept edge to the resp_valid cycle:
  - load: 2
  - word store: 2
  - sub-word store: 3
  - alignment fault: 1
- Throughput: one request in flight; req_ready = 0 outside IDLE.
- Request inputs are ignored while not in IDLE.
- Reset mid-operation: abort immediately. mem_we drops asynchronously. A sub-word store interrupted in RD never writes.
- Only the accept edge samples req_wdata, so changes to it during RMW have no effect.

Decomposition:
- Package arm_lsu_pkg:
  - size encodings (BYTE, HALF, WORD)
  - fault codes (FAULT_NONE, FAULT_ALIGN, FAULT_BUS)
  - state enum
  - memory map constants: data 0x10000000 size 0x100; text 0x00000000 size 0x100
- Sub-module arm_lsu_lane: combinational extract (addr[1:0], size, signed, word → value) and merge (word, addr[1:0], size, wdata → word). Shared by the RD path and the WR path.

Test Plan:
1. Word store 0xDEADBEEF to 0x10000010, then word load of the same address → store resp fault = 0 two cycles after accept; load resp_rdata = 0xDEADBEEF, fault = 0, two cycles after accept.
2. After test 1, byte store 0x11 to 0x10000012, then word load → RD then WR, mem_wdata = 0xDEAD11EF; load returns 0xDEAD11EF; store latency 3.
3. Signed byte load of 0x10000010 → 0xFFFFFFDE; unsigned → 0x000000DE. Signed half load of 0x10000012 → 0x000011EF.
4. Word load at 0x10000002 with ALIGN_CHECK = 1 → resp_valid one cycle after accept, fault = 1, mem_we never asserted. With ALIGN_CHECK = 0 → access to 0x10000000.
5. Byte store to 0x20000000 → fault = 2 in RESP, mem_we never asserted; memory contents unchanged.
6. Assert rst_n low during RD of a sub-word store to 0x10000020 → mem_we stays 0, req_ready = 1 after release, word at 0x10000020 unchanged.

Source files
------------

// File: rtl/arm_lsu_pkg.sv
// Shared encodings, state type and memory map for the load/store unit.
// Also holds the alignment helpers used when a request is accepted.
package arm_lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [1:0] FAULT_NONE  = 2'd0;
    localparam logic [1:0] FAULT_ALIGN = 2'd1;
    localparam logic [1:0] FAULT_BUS   = 2'd2;

    localparam logic [31:0] DATA_BASE = 32'h1000_0000;
    localparam logic [31:0] DATA_SIZE = 32'h0000_0100;
    localparam logic [31:0] TEXT_BASE = 32'h0000_0000;
    localparam logic [31:0] TEXT_SIZE = 32'h0000_0100;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StResp
    } lsu_state_e;

    // Size 3 is illegal and always counts as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return offset[0];
            SIZE_WORD: return |offset;
            default:   return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] force_align(input logic [1:0] size, input logic [31:0] addr);
        case (size)
            SIZE_BYTE: return addr;
            SIZE_HALF: return {addr[31:1], 1'b0};
            default:   return {addr[31:2], 2'b00};
        endcase
    endfunction

endpackage

// File: rtl/arm_lsu_lane.sv
// Big-endian lane extract (load path) and lane merge (read-modify-write path).
// Purely combinational; an illegal size behaves as a full word.
module arm_lsu_lane
    import arm_lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] extract,
    output logic [31:0] merged
);

    logic [4:0]  byte_lsb;
    logic [4:0]  half_lsb;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Offset 0 is the most significant byte, so the lane LSB is (3 - offset) * 8.
    assign byte_lsb = {~offset, 3'b000};
    assign half_lsb = {~offset[1], 4'b0000};
    assign byte_val = word[byte_lsb +: 8];
    assign half_val = word[half_lsb +: 16];

    always_comb begin
        extract = word;
        merged  = word;
        case (size)
            SIZE_BYTE: begin
                extract                = {{24{sign_ext & byte_val[7]}}, byte_val};
                merged[byte_lsb +: 8]  = wdata[7:0];
            end
            SIZE_HALF: begin
                extract                = {{16{sign_ext & half_val[15]}}, half_val};
                merged[half_lsb +: 16] = wdata[15:0];
            end
            default: begin
                extract = word;
                merged  = wdata;
            end
        endcase
    end

endmodule

// File: rtl/arm_lsu.sv
// Load/store unit driving the data port of a word-wide, big-endian memory.
// Sub-word stores are read-modify-write; one request is in flight at a time.
module arm_lsu
    import arm_lsu_pkg::*;
#(
    parameter bit          ALIGN_CHECK = 1'b1,
    parameter logic [31:0] RESET_RDATA = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic        mem_excpt,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic        write_q, write_d;
    logic [31:0] wword_q, wword_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  fault_q, fault_d;

    logic [31:0] lane_extract;
    logic [31:0] lane_merged;

    // wword_q holds the right-justified store data until RD replaces it with the merged word.
    arm_lsu_lane u_lane (
        .offset   (addr_q[1:0]),
        .size     (size_q),
        .sign_ext (signed_q),
        .word     (mem_rdata),
        .wdata    (wword_q),
        .extract  (lane_extract),
        .merged   (lane_merged)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        signed_d = signed_q;
        write_d  = write_q;
        wword_d  = wword_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d   = ALIGN_CHECK ? req_addr : force_align(req_size, req_addr);
                    size_d   = req_size;
                    signed_d = req_signed;
                    write_d  = req_write;
                    wword_d  = req_wdata;
                    if (ALIGN_CHECK && is_misaligned(req_size, req_addr[1:0])) begin
                        state_d = StResp;
                        fault_d = FAULT_ALIGN;
                        rdata_d = 32'h0;
                    end else if (req_write && req_size[1]) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                if (mem_excpt) begin
                    state_d = StResp;
                    fault_d = FAULT_BUS;
                    rdata_d = 32'h0;
                end else if (!write_q) begin
                    state_d = StResp;
                    fault_d = FAULT_NONE;
                    rdata_d = lane_extract;
                end else begin
                    state_d = StWr;
                    wword_d = lane_merged;
                end
            end
            StWr: begin
                state_d = StResp;
                fault_d = mem_excpt ? FAULT_BUS : FAULT_NONE;
                rdata_d = 32'h0;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            addr_q   <= 32'h0;
            size_q   <= SIZE_BYTE;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            wword_q  <= 32'h0;
            rdata_q  <= RESET_RDATA;
            fault_q  <= FAULT_NONE;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            write_q  <= write_d;
            wword_q  <= wword_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    // Memory-side outputs decode straight from state so reset drops mem_we asynchronously.
    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q;
    assign mem_we     = (state_q == StWr);
    assign mem_addr   = (state_q == StRd || state_q == StWr) ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wdata  = (state_q == StWr) ? wword_q : 32'h0;

endmodule

// File: tb/tb_arm_lsu.sv
// Scoreboard bench for arm_lsu: a byte-level reference memory predicts every response,
// a separate monitor pops predictions and compares whenever the DUT responds or writes.
`timescale 1ns/1ps
module tb_arm_lsu;
    import arm_lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, resp_valid, mem_we, mem_excpt;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  resp_fault;

    logic        u1_req_valid = 1'b0;
    logic [1:0]  u1_req_size = 2'd0;
    logic [31:0] u1_req_addr = 32'h0;
    logic        u1_req_ready, u1_resp_valid, u1_mem_we, u1_mem_excpt;
    logic [31:0] u1_resp_rdata, u1_mem_addr, u1_mem_wdata, u1_mem_rdata;
    logic [1:0]  u1_resp_fault;

    arm_lsu #(.ALIGN_CHECK(1'b1), .RESET_RDATA(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_excpt(mem_excpt), .mem_rdata(mem_rdata)
    );

    // Second instance without alignment checking; loads only, reads the same memory.
    arm_lsu #(.ALIGN_CHECK(1'b0), .RESET_RDATA(32'h0)) dut_noalign (
        .clk(clk), .rst_n(rst_n),
        .req_valid(u1_req_valid), .req_ready(u1_req_ready), .req_write(1'b0),
        .req_size(u1_req_size), .req_signed(1'b0), .req_addr(u1_req_addr),
        .req_wdata(32'h0), .resp_valid(u1_resp_valid), .resp_rdata(u1_resp_rdata),
        .resp_fault(u1_resp_fault), .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata),
        .mem_we(u1_mem_we), .mem_excpt(u1_mem_excpt), .mem_rdata(u1_mem_rdata)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  fault;
        int          lat;
        int          we;
        logic [31:0] waddr;
        logic [31:0] wword;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          we_cnt = 0;
    logic        mem_init = 1'b1;
    logic [31:0] dmem [64];
    logic [31:0] tmem [64];
    logic [7:0]  ref_mem [int unsigned];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic in_map(input logic [31:0] a);
        return ((a - DATA_BASE) < DATA_SIZE) || ((a - TEXT_BASE) < TEXT_SIZE);
    endfunction

    function automatic logic [31:0] init_word(input int region, input int i);
        return (32'(i) * 32'h9E37_79B9) ^ (region != 0 ? 32'h5A5A_0000 : 32'h0000_C3C3)
               ^ 32'h1357_9BDF;
    endfunction

    // Memory: combinational big-endian read, write committed at the clock edge.
    always_comb begin
        mem_excpt = !in_map(mem_addr);
        if ((mem_addr - DATA_BASE) < DATA_SIZE)      mem_rdata = dmem[mem_addr[7:2]];
        else if ((mem_addr - TEXT_BASE) < TEXT_SIZE) mem_rdata = tmem[mem_addr[7:2]];
        else                                         mem_rdata = 32'hA5A5_5A5A;
    end

    always_comb begin
        u1_mem_excpt = !in_map(u1_mem_addr);
        if ((u1_mem_addr - DATA_BASE) < DATA_SIZE)      u1_mem_rdata = dmem[u1_mem_addr[7:2]];
        else if ((u1_mem_addr - TEXT_BASE) < TEXT_SIZE) u1_mem_rdata = tmem[u1_mem_addr[7:2]];
        else                                            u1_mem_rdata = 32'hA5A5_5A5A;
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) begin
                dmem[i] <= init_word(1, i);
                tmem[i] <= init_word(0, i);
            end
        end else if (mem_we && !mem_excpt) begin
            if ((mem_addr - DATA_BASE) < DATA_SIZE) dmem[mem_addr[7:2]] <= mem_wdata;
            else                                    tmem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] wa);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < 4; i++) v = (v << 8) | 32'(ref_mem[wa + 32'(i)]);
        return v;
    endfunction

    // Reference: bytes addressed individually, most significant byte at the lowest address.
    task automatic ref_model(input bit wr, input logic [1:0] sz, input bit sg,
                             input logic [31:0] a, input logic [31:0] wd, output exp_t e);
        int unsigned n;
        logic [31:0] v;
        bit          ok;
        n  = 32'd1 << sz;
        ok = in_map(a);
        e  = '{rdata: 32'h0, fault: FAULT_NONE, lat: 2, we: 0, waddr: a & ~32'h3,
               wword: 32'h0, acc: 0};
        if (sz == 2'd3 || (a % n) != 0) begin
            e.fault = FAULT_ALIGN;
            e.lat   = 1;
            return;
        end
        if (!wr) begin
            if (!ok) begin
                e.fault = FAULT_BUS;
            end else begin
                v = 32'h0;
                for (int unsigned i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[a + i]);
                if (sg && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
                e.rdata = v;
            end
        end else if (sz == 2'd2) begin
            e.we    = 1;
            e.wword = wd;
            if (!ok) e.fault = FAULT_BUS;
            else for (int unsigned i = 0; i < 4; i++) ref_mem[a + i] = 8'(wd >> (8*(3-i)));
        end else if (!ok) begin
            e.fault = FAULT_BUS;
        end else begin
            for (int unsigned i = 0; i < n; i++) ref_mem[a + i] = 8'(wd >> (8*(n-1-i)));
            e.we    = 1;
            e.lat   = 3;
            e.wword = ref_word(a & ~32'h3);
        end
    endtask

    // Monitor: compares writes against the head prediction and pops on each response.
    always @(negedge clk) begin
        if (!rst_n) begin
            we_cnt = 0;
        end else begin
            if (mem_we) begin
                we_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_write", 32'(mem_we), 32'h0);
                end else begin
                    chk("wr_addr", mem_addr, sb[0].waddr);
                    chk("wr_data", mem_wdata, sb[0].wword);
                end
            end
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'(resp_valid), 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_fault", 32'(resp_fault), 32'(e.fault));
                    chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                    chk("write_count", 32'(we_cnt), 32'(e.we));
                end
                we_cnt = 0;
            end
        end
    end

    task automatic wait_ready(output bit ok);
        int t = 0;
        while (!req_ready && t < 50) begin
            // Junk on the request lines while busy must be ignored.
            req_valid  = 1'($urandom_range(0, 1));
            req_write  = 1'($urandom_range(0, 1));
            req_size   = 2'($urandom_range(0, 3));
            req_addr   = $urandom;
            req_wdata  = $urandom;
            @(negedge clk);
            t++;
        end
        ok = req_ready;
        if (!ok) chk("ready_timeout", 32'(req_ready), 32'h1);
    endtask

    task automatic issue(input bit wr, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        bit   ok;
        @(negedge clk);
        wait_ready(ok);
        if (ok) begin
            ref_model(wr, sz, sg, a, wd, e);
            e.acc = cyc + 1;
            sb.push_back(e);
            req_valid  = 1'b1;
            req_write  = wr;
            req_size   = sz;
            req_signed = sg;
            req_addr   = a;
            req_wdata  = wd;
            @(posedge clk);
            #1;
            req_valid  = 1'b0;
            req_wdata  = $urandom;
        end
    endtask

    task automatic issue_noalign(input logic [1:0] sz, input logic [31:0] a);
        exp_t        e;
        logic [31:0] seen = 32'h0;
        int          t = 0;
        ref_model(1'b0, sz, 1'b0, a & ~((32'd1 << sz) - 32'd1), 32'h0, e);
        @(negedge clk);
        u1_req_valid = 1'b1;
        u1_req_size  = sz;
        u1_req_addr  = a;
        @(posedge clk);
        #1;
        u1_req_valid = 1'b0;
        while (!u1_resp_valid && t < 10) begin
            if (u1_mem_addr != 32'h0) seen = u1_mem_addr;
            @(negedge clk);
            t++;
        end
        chk("noalign_addr", seen, a & ~32'h3);
        chk("noalign_resp_seen", 32'(u1_resp_valid), 32'h1);
        chk("noalign_rdata", u1_resp_rdata, e.rdata);
        chk("noalign_fault", 32'(u1_resp_fault), 32'(FAULT_NONE));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          t;
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;

        for (int i = 0; i < 64; i++) begin
            for (int b = 0; b < 4; b++) begin
                ref_mem[DATA_BASE + 32'(4*i + b)] = 8'(init_word(1, i) >> (8*(3-b)));
                ref_mem[TEXT_BASE + 32'(4*i + b)] = 8'(init_word(0, i) >> (8*(3-b)));
            end
        end

        repeat (3) @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_fault", 32'(resp_fault), 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;
        mem_init = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h1);

        issue_noalign(SIZE_WORD, 32'h1000_0002);
        issue_noalign(SIZE_HALF, 32'h1000_0007);

        issue(1'b1, SIZE_WORD, 1'b0, 32'h1000_0010, 32'hDEAD_BEEF);
        issue(1'b0, SIZE_WORD, 1'b0, 32'h1000_0010, 32'h0);
        issue(1'b1, SIZE_BYTE, 1'b0, 32'h1000_0012, 32'h0000_0011);
        issue(1'b0, SIZE_WORD, 1'b0, 32'h1000_0010, 32'h0);
        issue(1'b0, SIZE_BYTE, 1'b1, 32'h1000_0010, 32'h0);
        issue(1'b0, SIZE_BYTE, 1'b0, 32'h1000_0010, 32'h0);
        issue(1'b0, SIZE_HALF, 1'b1, 32'h1000_0012, 32'h0);
        issue(1'b0, SIZE_WORD, 1'b0, 32'h1000_0002, 32'h0);
        issue(1'b1, SIZE_BYTE, 1'b0, 32'h2000_0000, 32'h0000_0055);
        issue(1'b1, 2'd3, 1'b0, 32'h1000_0020, 32'h1234_5678);

        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 9);
            if (r < 7)      a = DATA_BASE + $urandom_range(0, 255);
            else if (r < 9) a = TEXT_BASE + $urandom_range(0, 255);
            else            a = 32'h2000_0000 + $urandom_range(0, 4095);
            r = $urandom_range(0, 9);
            sz = (r < 3) ? SIZE_BYTE : (r < 6) ? SIZE_HALF : (r < 9) ? SIZE_WORD : 2'd3;
            if ($urandom_range(0, 3) == 0) a = a & ~32'h3;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end

        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_scoreboard", 32'(sb.size()), 32'h0);

        // Reset while a sub-word store sits in RD: the write must never happen.
        @(negedge clk);
        wait_ready(ok);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = SIZE_BYTE;
        req_addr  = 32'h1000_0020;
        req_wdata = 32'h0000_00AA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("abort_in_rd_addr", mem_addr, 32'h1000_0020);
        chk("abort_in_rd_we", 32'(mem_we), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("abort_we_async", 32'(mem_we), 32'h0);
        chk("abort_addr_async", mem_addr, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_req_ready", 32'(req_ready), 32'h1);
        chk("abort_resp_valid", 32'(resp_valid), 32'h0);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 64; i++) begin
            chk("mem_data_word", dmem[i], ref_word(DATA_BASE + 32'(4*i)));
            chk("mem_text_word", tmem[i], ref_word(TEXT_BASE + 32'(4*i)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
